stage_execute_mdu: RTL and testbench

STAGE_EXECUTE_MDU -- requirements
Module: stage_execute_mdu

---
 rtl/stage_execute_mdu_if.sv | 27 ++
 rtl/stage_execute_mdu.sv | 138 +++++++++++++
 tb/tb_stage_execute_mdu.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_execute_mdu_if.sv
`default_nettype none
// ============================================================================
// Module   : stage_execute_mdu_if
// Purpose  : Request/result bundle between the execute stage and the MDU.
// Revision : 1.0
// ============================================================================
interface stage_execute_mdu_if;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdu_op, in0, in1,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, mdu_op, in0, in1,
        output busy, stall, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/stage_execute_mdu.sv
`default_nettype none
// ============================================================================
// Module   : stage_execute_mdu
// Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Revision : 1.0
// ============================================================================
module stage_execute_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic          clk,
    input  wire logic          reset,
    stage_execute_mdu_if.slave bus
);

    localparam int CNT_W = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam logic [1:0]       C_OP_MULT   = 2'd0;
    localparam logic [1:0]       C_OP_MULTU  = 2'd1;
    localparam logic [1:0]       C_OP_DIV    = 2'd2;
    localparam logic [2:0]       C_OP_MTHI   = 3'd4;
    localparam logic [2:0]       C_OP_MTLO   = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_busy;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_write;

    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_signed_div = (r_op == C_OP_DIV);
    assign w_dvd = (w_signed_div && r_a[31]) ? (~r_a + 32'd1) : r_a;
    assign w_dvs = (w_signed_div && r_b[31]) ? (~r_b + 32'd1) : r_b;
    assign w_q   = w_dvd / w_dvs;
    assign w_r   = w_dvd % w_dvs;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (r_op)
            C_OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            C_OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            C_OP_DIV: begin
                w_res_lo = (r_a[31] ^ r_b[31]) ? (~w_q + 32'd1) : w_q;
                w_res_hi = r_a[31] ? (~w_r + 32'd1) : w_r;
            end
            default: begin
                w_res_lo = w_q;
                w_res_hi = w_r;
            end
        endcase
    end

    // Divide by zero still burns the full latency but commits nothing.
    assign w_write = !(r_op[1] && (r_b == 32'd0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= 2'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (!bus.mdu_op[2]) begin
                            r_op    <= bus.mdu_op[1:0];
                            r_a     <= bus.in0;
                            r_b     <= bus.in1;
                            r_cnt   <= bus.mdu_op[1] ? C_DIV_LOAD : C_MULT_LOAD;
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end else if (bus.mdu_op == C_OP_MTHI) begin
                            r_hi <= bus.in0;
                        end else if (bus.mdu_op == C_OP_MTLO) begin
                            r_lo <= bus.in0;
                        end
                    end
                end
                default: begin
                    if (r_cnt <= C_ONE) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        if (w_write) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
    assign bus.stall = bus.start & r_busy;

endmodule
`default_nettype wire

// File: tb/tb_stage_execute_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_execute_mdu
// Purpose  : Self-checking bench for stage_execute_mdu against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_stage_execute_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Expected architectural state and remaining busy cycles.
    logic [31:0] exp_hi, exp_lo, pend_hi, pend_lo;
    bit          pend_wr;
    int          exp_rem;

    stage_execute_mdu_if bus();

    stage_execute_mdu #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void ref_result(input logic [2:0] op, input logic [31:0] a, b,
                                       output logic [31:0] rh, rl, output bit wr);
        int ia, ib;
        longint la, lb, p;
        longint unsigned ua, ub, pu;
        ia = a; ib = b;
        la = ia; lb = ib;
        ua = a;  ub = b;
        rh = 32'd0; rl = 32'd0; wr = 1'b1;
        case (op)
            3'd0: begin p = la * lb; rh = p[63:32]; rl = p[31:0]; end
            3'd1: begin pu = ua * ub; rh = pu[63:32]; rl = pu[31:0]; end
            3'd2: begin
                if (b == 32'd0) wr = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    rl = 32'h8000_0000; rh = 32'd0;
                end else begin
                    rl = ia / ib; rh = ia % ib;
                end
            end
            default: begin
                if (b == 32'd0) wr = 1'b0;
                else begin rl = a / b; rh = a % b; end
            end
        endcase
    endfunction

    // Advance the reference by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        if (reset) begin
            exp_hi = 32'd0; exp_lo = 32'd0; exp_rem = 0; pend_wr = 1'b0;
        end else if (exp_rem > 0) begin
            exp_rem--;
            if (exp_rem == 0 && pend_wr) begin
                exp_hi = pend_hi; exp_lo = pend_lo;
            end
        end else if (bus.start) begin
            case (bus.mdu_op)
                3'd0, 3'd1: begin
                    exp_rem = MULT_N;
                    ref_result(bus.mdu_op, bus.in0, bus.in1, pend_hi, pend_lo, pend_wr);
                end
                3'd2, 3'd3: begin
                    exp_rem = DIV_N;
                    ref_result(bus.mdu_op, bus.in0, bus.in1, pend_hi, pend_lo, pend_wr);
                end
                3'd4: exp_hi = bus.in0;
                3'd5: exp_lo = bus.in0;
                default: ;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, "_hi"},    bus.hi, exp_hi);
        chk({tag, "_lo"},    bus.lo, exp_lo);
        chk({tag, "_busy"},  {31'd0, bus.busy},  {31'd0, exp_rem > 0});
        chk({tag, "_stall"}, {31'd0, bus.stall}, {31'd0, bus.start && exp_rem > 0});
    endtask

    // Issue one op and follow it to completion, optionally hammering start while busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, input bit poke,
                          output int busy_cycles);
        int guard;
        bus.start = 1'b1; bus.mdu_op = op; bus.in0 = a; bus.in1 = b;
        step();
        bus.start = 1'b0;
        busy_cycles = 0;
        guard = 0;
        while (exp_rem > 0 && guard < 64) begin
            if (poke && exp_rem > 1) begin
                bus.start  = 1'b1;
                bus.mdu_op = 3'($urandom_range(0, 7));
                bus.in0    = $urandom;
                bus.in1    = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            check_all("run");
            if (bus.busy) busy_cycles++;
            step();
            guard++;
        end
        bus.start = 1'b0;
        chk("run_bound", {31'd0, guard < 64}, 32'd1);
        check_all("done");
    endtask

    initial begin
        int nb;
        logic [2:0]  op;
        logic [31:0] a, b;
        checks = 0; errors = 0;
        exp_hi = 32'hDEAD_BEEF; exp_lo = 32'hDEAD_BEEF; exp_rem = 0; pend_wr = 1'b0;
        pend_hi = 32'd0; pend_lo = 32'd0;
        bus.start = 1'b0; bus.mdu_op = 3'd0; bus.in0 = 32'd0; bus.in1 = 32'd0;
        reset = 1'b1;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        check_all("reset");
        chk("reset_hi_zero", bus.hi, 32'd0);

        // MTHI in idle: immediate write, no busy
        bus.start = 1'b1; bus.mdu_op = 3'd4; bus.in0 = 32'hA5A5_A5A5;
        step();
        bus.start = 1'b0;
        check_all("mthi");
        chk("mthi_hi", bus.hi, 32'hA5A5_A5A5);

        run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, nb);
        chk("mult_cycles", 32'(nb), 32'd5);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFA);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, nb);
        chk("multu_cycles", 32'(nb), 32'd5);
        chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 32'h0000_0001);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, nb);
        chk("div_cycles", 32'(nb), 32'd10);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);

        run_op(3'd3, 32'd7, 32'd0, 1'b0, nb);
        chk("divu0_cycles", 32'(nb), 32'd10);
        chk("divu0_lo", bus.lo, 32'hFFFF_FFFD);
        chk("divu0_hi", bus.hi, 32'hFFFF_FFFF);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb);
        chk("divovf_lo", bus.lo, 32'h8000_0000);
        chk("divovf_hi", bus.hi, 32'd0);

        // MTLO held against a busy DIV must stall, then land once busy drops
        bus.start = 1'b1; bus.mdu_op = 3'd2; bus.in0 = 32'd100; bus.in1 = 32'd7;
        step();
        bus.mdu_op = 3'd5; bus.in0 = 32'h1234_5678; bus.in1 = 32'd0;
        for (int i = 0; i < DIV_N; i++) begin
            check_all("mtlo_wait");
            chk("mtlo_stall", {31'd0, bus.stall}, 32'd1);
            step();
        end
        check_all("mtlo_free");
        chk("mtlo_divq", bus.lo, 32'd14);
        chk("mtlo_divr", bus.hi, 32'd2);
        step();
        bus.start = 1'b0;
        check_all("mtlo_done");
        chk("mtlo_lo", bus.lo, 32'h1234_5678);

        // Reserved op is a no-op
        bus.start = 1'b1; bus.mdu_op = 3'd6; bus.in0 = 32'hFFFF_0000;
        step();
        bus.start = 1'b0;
        check_all("reserved");

        // Reset in RUN cycle 3 aborts the MULT with no late write
        bus.start = 1'b1; bus.mdu_op = 3'd0; bus.in0 = 32'd9; bus.in1 = 32'd9;
        step();
        bus.start = 1'b0;
        check_all("abort_c1");
        step();
        check_all("abort_c2");
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all("abort_rst");
        for (int i = 0; i < 8; i++) begin
            step();
            check_all("abort_after");
        end
        chk("abort_lo", bus.lo, 32'd0);

        // Reset on the completion edge discards the result
        bus.start = 1'b1; bus.mdu_op = 3'd1; bus.in0 = 32'd3; bus.in1 = 32'd5;
        step();
        bus.start = 1'b0;
        while (exp_rem > 1) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all("rst_at_done");
        step();
        check_all("rst_at_done_after");

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 15);
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if (op == 3'd2 && $urandom_range(0, 7) == 0) begin
                a = 32'h8000_0000; b = 32'hFFFF_FFFF;
            end
            if (!op[2]) begin
                run_op(op, a, b, $urandom_range(0, 1) == 1, nb);
            end else begin
                bus.start = 1'b1; bus.mdu_op = op; bus.in0 = a; bus.in1 = b;
                step();
                bus.start = 1'b0;
                check_all("rnd_move");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
